// File: rtl/ram_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_seq
// Description : Serialises multi-byte load/store/fetch requests from
//               NUM_PORTS requesters onto one byte-wide synchronous RAM port.
//               Owns the grant, walks the bytes of each access, assembles
//               read words little-endian and pulses done to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_seq #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int ARB_MODE   = 0
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [NUM_PORTS-1:0]             req_i,
   input  logic [NUM_PORTS-1:0]             we_i,
   input  logic [2*NUM_PORTS-1:0]           size_i,
   input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  addr_i,
   input  logic [32*NUM_PORTS-1:0]          wdata_i,
   output logic [NUM_PORTS-1:0]             grant_o,
   output logic [NUM_PORTS-1:0]             done_o,
   output logic [31:0]                      rdata_o,
   output logic                             busy_o,
   output logic [ADDR_WIDTH-1:0]            mem_a_o,
   output logic [7:0]                       mem_dout_o,
   output logic                             mem_wr_o,
   input  logic [7:0]                       mem_din_i
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_TAIL = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_idx;       // index of the current owner
   logic [IDX_W-1:0]       r_rr_ptr;    // last port served (round robin)
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic                   r_we;
   logic [1:0]             r_last;      // byte count minus one: 0, 1 or 3
   logic [31:0]            r_wdata;
   logic [1:0]             r_k;         // byte index within the access
   logic [31:0]            r_acc;       // read word being assembled

   logic [NUM_PORTS-1:0]   w_above;
   logic [NUM_PORTS-1:0]   w_pool;
   logic [NUM_PORTS-1:0]   w_win_oh;
   logic [IDX_W-1:0]       w_win_idx;
   logic [ADDR_WIDTH-1:0]  w_win_addr;
   logic                   w_win_we;
   logic [1:0]             w_win_size;
   logic [31:0]            w_win_wdata;
   logic [1:0]             w_win_last;
   logic [1:0]             w_k_next;
   logic [1:0]             w_k_prev;
   logic [31:0]            w_acc_cap;
   logic [31:0]            w_acc_fin;

   // Winner selection: round robin restricts the pool to ports above the
   // pointer when any of them request, otherwise lowest requesting index wins.
   always_comb begin
      w_above = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (j > int'(r_rr_ptr)) begin
            w_above[j] = req_i[j];
         end
      end
      if ((ARB_MODE == 1) && (|w_above)) begin
         w_pool = w_above;
      end else begin
         w_pool = req_i;
      end
      w_win_oh    = '0;
      w_win_idx   = '0;
      w_win_addr  = '0;
      w_win_we    = 1'b0;
      w_win_size  = '0;
      w_win_wdata = '0;
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (w_pool[j]) begin
            w_win_oh    = '0;
            w_win_oh[j] = 1'b1;
            w_win_idx   = IDX_W'(j);
            w_win_addr  = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
            w_win_we    = we_i[j];
            w_win_size  = size_i[2*j +: 2];
            w_win_wdata = wdata_i[32*j +: 32];
         end
      end
      case (w_win_size)
         2'b00:   w_win_last = 2'd0;
         2'b01:   w_win_last = 2'd1;
         default: w_win_last = 2'd3;
      endcase
   end

   // Byte stepping and read-byte merge into the accumulator.
   always_comb begin
      w_k_next  = r_k + 2'd1;
      w_k_prev  = r_k - 2'd1;
      w_acc_cap = r_acc;
      w_acc_cap[{w_k_prev, 3'b000} +: 8] = mem_din_i;
      w_acc_fin = r_acc;
      w_acc_fin[{r_last, 3'b000} +: 8] = mem_din_i;
   end

   // Transfer FSM; every output is registered so the RAM sees clean strobes.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_rr_ptr   <= IDX_W'(NUM_PORTS - 1);
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_last     <= '0;
         r_wdata    <= '0;
         r_k        <= '0;
         r_acc      <= '0;
         grant_o    <= '0;
         done_o     <= '0;
         rdata_o    <= '0;
         busy_o     <= 1'b0;
         mem_a_o    <= '0;
         mem_dout_o <= '0;
         mem_wr_o   <= 1'b0;
      end else begin
         done_o <= '0;
         case (r_state)
            S_IDLE: begin
               mem_wr_o <= 1'b0;
               if (|req_i) begin
                  r_idx      <= w_win_idx;
                  r_addr     <= w_win_addr;
                  r_we       <= w_win_we;
                  r_last     <= w_win_last;
                  r_wdata    <= w_win_wdata;
                  r_k        <= '0;
                  r_acc      <= '0;
                  grant_o    <= w_win_oh;
                  busy_o     <= 1'b1;
                  mem_a_o    <= w_win_addr;
                  mem_wr_o   <= w_win_we;
                  mem_dout_o <= w_win_wdata[7:0];
                  r_state    <= S_XFER;
               end
            end
            S_XFER: begin
               // RAM answers one cycle late, so byte k-1 arrives during step k.
               if (!r_we && (r_k != 2'd0)) begin
                  r_acc <= w_acc_cap;
               end
               if (r_k == r_last) begin
                  mem_wr_o <= 1'b0;
                  if (r_we) begin
                     done_o  <= grant_o;
                     rdata_o <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_TAIL;
                  end
               end else begin
                  r_k        <= w_k_next;
                  mem_a_o    <= r_addr + ADDR_WIDTH'(w_k_next);
                  mem_dout_o <= r_wdata[{w_k_next, 3'b000} +: 8];
               end
            end
            S_TAIL: begin
               mem_wr_o <= 1'b0;
               r_acc    <= w_acc_fin;
               rdata_o  <= w_acc_fin;
               done_o   <= grant_o;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               mem_wr_o <= 1'b0;
               grant_o  <= '0;
               busy_o   <= 1'b0;
               if (ARB_MODE == 1) begin
                  r_rr_ptr <= r_idx;
               end
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter_seq
// Description : Self-checking bench for ram_arbiter_seq. One fixed-priority
//               and one round-robin instance share stimulus; a scoreboard
//               queue holds expected done/rdata pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_seq;

   typedef struct packed {
      logic [1:0]  done;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, we;
   logic [3:0]  size;
   logic [63:0] addr, wdata;
   logic        use_rr;

   logic [1:0]  grant_fp, done_fp, grant_rr, done_rr;
   logic [31:0] rdata_fp, rdata_rr, mem_a_fp, mem_a_rr;
   logic        busy_fp, busy_rr, mem_wr_fp, mem_wr_rr;
   logic [7:0]  mem_dout_fp, mem_dout_rr, din_fp, din_rr;

   logic [1:0]  cur_grant, cur_done;
   logic [31:0] cur_rdata, cur_mem_a;
   logic        cur_busy, cur_mem_wr;
   logic [7:0]  cur_mem_dout;

   logic [7:0]  ram [0:4095];
   logic        pre_we;
   logic [11:0] pre_a;
   logic [7:0]  pre_d;

   exp_t        sb_q[$];
   logic [31:0] a_log[$];
   int          wr_cnt, wr_viol;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk = ~clk;

   ram_arbiter_seq #(.NUM_PORTS(2), .ADDR_WIDTH(32), .ARB_MODE(0)) u_dut_fp (
      .clk_in(clk), .rst_in(rst), .req_i(req), .we_i(we), .size_i(size),
      .addr_i(addr), .wdata_i(wdata), .grant_o(grant_fp), .done_o(done_fp),
      .rdata_o(rdata_fp), .busy_o(busy_fp), .mem_a_o(mem_a_fp),
      .mem_dout_o(mem_dout_fp), .mem_wr_o(mem_wr_fp), .mem_din_i(din_fp)
   );

   ram_arbiter_seq #(.NUM_PORTS(2), .ADDR_WIDTH(32), .ARB_MODE(1)) u_dut_rr (
      .clk_in(clk), .rst_in(rst), .req_i(req), .we_i(we), .size_i(size),
      .addr_i(addr), .wdata_i(wdata), .grant_o(grant_rr), .done_o(done_rr),
      .rdata_o(rdata_rr), .busy_o(busy_rr), .mem_a_o(mem_a_rr),
      .mem_dout_o(mem_dout_rr), .mem_wr_o(mem_wr_rr), .mem_din_i(din_rr)
   );

   assign cur_grant    = use_rr ? grant_rr    : grant_fp;
   assign cur_done     = use_rr ? done_rr     : done_fp;
   assign cur_rdata    = use_rr ? rdata_rr    : rdata_fp;
   assign cur_busy     = use_rr ? busy_rr     : busy_fp;
   assign cur_mem_a    = use_rr ? mem_a_rr    : mem_a_fp;
   assign cur_mem_wr   = use_rr ? mem_wr_rr   : mem_wr_fp;
   assign cur_mem_dout = use_rr ? mem_dout_rr : mem_dout_fp;

   // Synchronous byte RAM for the fixed instance; the strobe is gated by reset.
   always @(posedge clk) begin
      if (pre_we) begin
         ram[pre_a] <= pre_d;
      end else if (mem_wr_fp && !rst) begin
         ram[mem_a_fp[11:0]] <= mem_dout_fp;
      end
      din_fp <= ram[mem_a_fp[11:0]];
   end

   // The round-robin instance reads a pattern derived from its address.
   always @(posedge clk) begin
      din_rr <= mem_a_rr[7:0] ^ 8'h5A;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Scoreboard and bus monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst && (cur_done != 2'b00)) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_done", {62'd0, cur_done}, 64'd0);
         end else begin
            check("sb_done", {62'd0, cur_done}, {62'd0, sb_q[0].done});
            check("sb_rdata", {32'd0, cur_rdata}, {32'd0, sb_q[0].rdata});
            check("grant_owner", {62'd0, cur_grant}, {62'd0, cur_done});
            void'(sb_q.pop_front());
         end
      end
      if (cur_busy) a_log.push_back(cur_mem_a);
      if (cur_mem_wr) wr_cnt <= wr_cnt + 1;
      if (cur_mem_wr && !cur_busy) wr_viol <= wr_viol + 1;
   end

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      pre_a = a; pre_d = d; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic set_port(input int p, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
      we[p] = w;
      size[2*p +: 2] = sz;
      addr[32*p +: 32] = a;
      wdata[32*p +: 32] = wd;
   endtask

   // One request from one port; called and returns just after a rising edge.
   task automatic single(input int p, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input int exp_lat, input string tag);
      int lat;
      bit got;
      logic [1:0] oh;
      oh = 2'b00;
      oh[p] = 1'b1;
      set_port(p, w, sz, a, wd);
      sb_q.push_back({oh, exp_rd});
      a_log.delete();
      wr_cnt = 0;
      req[p] = 1'b1;
      lat = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (cur_done[p]) got = 1'b1;
      end
      check({tag, "_latency"}, got ? 64'(lat) : 64'hDEAD, 64'(exp_lat));
      @(posedge clk); #1;
      req[p] = 1'b0;
   endtask

   // Both ports request together and each drops req after its own done.
   task automatic both(input logic [1:0] first, input logic [31:0] rd_first,
                       input logic [1:0] second, input logic [31:0] rd_second,
                       input string tag);
      logic [1:0] order [2];
      int t [2];
      int cyc, nd;
      logic [1:0] clr;
      sb_q.push_back({first, rd_first});
      sb_q.push_back({second, rd_second});
      order[0] = 2'b00; order[1] = 2'b00; t[0] = 0; t[1] = 0;
      cyc = 0; nd = 0; clr = 2'b00;
      req = 2'b11;
      for (int i = 0; i < 40 && nd < 2; i++) begin
         @(posedge clk); #1;
         req = req & ~clr;
         clr = 2'b00;
         cyc++;
         @(negedge clk);
         if (cur_done != 2'b00) begin
            order[nd] = cur_done;
            t[nd] = cyc;
            clr = cur_done;
            nd++;
         end
      end
      @(posedge clk); #1;
      req = req & ~clr;
      check({tag, "_first"}, {62'd0, order[0]}, {62'd0, first});
      check({tag, "_second"}, {62'd0, order[1]}, {62'd0, second});
      check({tag, "_gap"}, 64'(t[1] - t[0]), 64'd4);
   endtask

   initial begin
      rst = 1'b1; req = '0; we = '0; size = '0; addr = '0; wdata = '0;
      pre_we = 1'b0; pre_a = '0; pre_d = '0; use_rr = 1'b0;
      wr_cnt = 0; wr_viol = 0;
      repeat (2) @(posedge clk);
      #1;
      poke(12'h100, 8'h11); poke(12'h101, 8'h22);
      poke(12'h102, 8'h33); poke(12'h103, 8'h44);
      poke(12'h020, 8'h5A); poke(12'h021, 8'h5A); poke(12'h022, 8'h5A);
      for (int i = 0; i < 4; i++) poke(12'h040 + 12'(i), 8'hEE);
      poke(12'h300, 8'h80);
      poke(12'hFFE, 8'h01); poke(12'hFFF, 8'h02);
      poke(12'h000, 8'h03); poke(12'h001, 8'h04);

      // Reset state
      @(negedge clk);
      check("reset_ctl", {58'd0, cur_grant, cur_done, cur_busy, cur_mem_wr}, 64'd0);
      check("reset_data", {cur_rdata, cur_mem_a}, 64'd0);
      check("reset_dout", {56'd0, cur_mem_dout}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Port 1 reads 4 bytes at 0x100
      single(1, 1'b0, 2'b10, 32'h100, 32'h0, 32'h44332211, 6, "rd4");
      for (int i = 0; i < 4; i++)
         check("rd4_addr", {32'd0, a_log[i]}, 64'h100 + 64'(i));
      @(negedge clk);
      check("rdata_hold", {32'd0, cur_rdata}, 64'h44332211);
      @(posedge clk); #1;

      // Port 0 writes 2 bytes at 0x20
      single(0, 1'b1, 2'b01, 32'h20, 32'hAABBCCDD, 32'h0, 3, "wr2");
      check("wr2_strobes", 64'(wr_cnt), 64'd2);
      check("wr2_b0", {56'd0, ram[12'h020]}, 64'hDD);
      check("wr2_b1", {56'd0, ram[12'h021]}, 64'hCC);
      check("wr2_b2", {56'd0, ram[12'h022]}, 64'h5A);

      // Simultaneous requests, fixed priority
      set_port(0, 1'b0, 2'b00, 32'h100, 32'h0);
      set_port(1, 1'b0, 2'b00, 32'h103, 32'h0);
      both(2'b01, 32'h11, 2'b10, 32'h44, "fp");

      // Address wrap with size 11 treated as 4 bytes
      single(0, 1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, 32'h04030201, 6, "wrap");
      check("wrap_a0", {32'd0, a_log[0]}, 64'hFFFFFFFE);
      check("wrap_a1", {32'd0, a_log[1]}, 64'hFFFFFFFF);
      check("wrap_a2", {32'd0, a_log[2]}, 64'h00000000);
      check("wrap_a3", {32'd0, a_log[3]}, 64'h00000001);

      // Reset during the second byte of a 4-byte store
      set_port(0, 1'b1, 2'b10, 32'h40, 32'h11223344);
      req[0] = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      req = 2'b00;
      @(negedge clk);
      check("rstmid_byte2", {31'd0, cur_mem_wr, cur_mem_a}, {31'd0, 1'b1, 32'h41});
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_ctl", {58'd0, cur_grant, cur_done, cur_busy, cur_mem_wr}, 64'd0);
      check("rstmid_data", {cur_rdata, cur_mem_a}, 64'd0);
      repeat (8) @(posedge clk);
      #1;
      check("rstmid_ram", {32'd0, ram[12'h040], ram[12'h041], ram[12'h042], ram[12'h043]},
            64'h44EEEEEE);

      // One-byte read of 0x80 is zero-extended
      single(1, 1'b0, 2'b00, 32'h300, 32'h0, 32'h00000080, 3, "rd1");

      // Round-robin instance
      use_rr = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_port(0, 1'b0, 2'b00, 32'h10, 32'h0);
      set_port(1, 1'b0, 2'b00, 32'h20, 32'h0);
      both(2'b01, 32'h4A, 2'b10, 32'h7A, "rr1");
      both(2'b01, 32'h4A, 2'b10, 32'h7A, "rr2");
      single(0, 1'b0, 2'b00, 32'h10, 32'h0, 32'h4A, 3, "rr_solo");
      set_port(1, 1'b0, 2'b00, 32'h20, 32'h0);
      both(2'b10, 32'h7A, 2'b01, 32'h4A, "rr3");

      @(negedge clk);
      check("wr_outside_xfer", 64'(wr_viol), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
